// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire neuron blocks.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lif_state_e;

  localparam int THRESH_RST_DEF = 230;

  // Leak is s*(1/2 + 1/4 + 1/8), built from three right shifts.
  localparam int LEAK_SH1 = 1;
  localparam int LEAK_SH2 = 2;
  localparam int LEAK_SH3 = 3;

endpackage

// File: rtl/lif_update.sv
// Combinational leak-and-fire update for one neuron; shared by the standalone
// neuron and the time-multiplexed scheduler.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] next_s,
  output logic             fire
);

  localparam logic [WIDTH+1:0] SAT_MAX = {2'b00, {WIDTH{1'b1}}};

  logic [WIDTH+1:0] sum_s;

  // Fire on the pre-update state; otherwise integrate with a saturating leak sum.
  always_comb begin
    fire   = 1'b0;
    next_s = {WIDTH{1'b0}};
    sum_s  = {2'b00, c} + {2'b00, (s >> LEAK_SH1)} + {2'b00, (s >> LEAK_SH2)}
           + {2'b00, (s >> LEAK_SH3)};
    if (s >= threshold) begin
      fire   = 1'b1;
      next_s = {WIDTH{1'b0}};
    end else if (sum_s > SAT_MAX) begin
      next_s = {WIDTH{1'b1}};
    end else begin
      next_s = sum_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Sweeps one shared LIF update datapath across N_NEURONS membrane registers
// per timestep and presents the resulting spike vector on a valid/ready port.
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 8,
  parameter int WIDTH      = 8,
  parameter int THRESH_RST = THRESH_RST_DEF,
  parameter int IDX_W      = $clog2(N_NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step_valid,
  output logic                       step_ready,
  input  logic [N_NEURONS*WIDTH-1:0] currents,
  output logic                       spikes_valid,
  input  logic                       spikes_ready,
  output logic [N_NEURONS-1:0]       spikes,
  input  logic                       thr_wr_en,
  input  logic [WIDTH-1:0]           thr_wr_data,
  output logic [WIDTH-1:0]           threshold,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [WIDTH-1:0]           rd_state,
  output logic [15:0]                step_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [WIDTH-1:0] THR_INIT = WIDTH'(THRESH_RST);

  lif_state_e                 state_r;
  logic [IDX_W-1:0]           idx_r;
  logic [WIDTH-1:0]           mem_r [N_NEURONS];
  logic [N_NEURONS*WIDTH-1:0] cur_r;
  logic [N_NEURONS-1:0]       spikes_r;
  logic [WIDTH-1:0]           threshold_r;
  logic [15:0]                step_count_r;
  logic                       step_ready_r;
  logic                       spikes_valid_r;

  logic [WIDTH-1:0]           cur_sel_s;
  logic [WIDTH-1:0]           state_sel_s;
  logic [WIDTH-1:0]           next_state_s;
  logic                       fire_s;

  assign cur_sel_s   = cur_r[idx_r*WIDTH +: WIDTH];
  assign state_sel_s = mem_r[idx_r];

  lif_update #(
    .WIDTH(WIDTH)
  ) u_update (
    .s        (state_sel_s),
    .c        (cur_sel_s),
    .threshold(threshold_r),
    .next_s   (next_state_s),
    .fire     (fire_s)
  );

  // Timestep FSM, membrane register file and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      idx_r          <= {IDX_W{1'b0}};
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      cur_r          <= {(N_NEURONS*WIDTH){1'b0}};
      spikes_r       <= {N_NEURONS{1'b0}};
      threshold_r    <= THR_INIT;
      step_count_r   <= 16'd0;
      step_ready_r   <= 1'b1;
      spikes_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (thr_wr_en) begin
            threshold_r <= thr_wr_data;
          end
          if (step_valid) begin
            cur_r        <= currents;
            spikes_r     <= {N_NEURONS{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            state_r      <= ST_RUN;
            step_ready_r <= 1'b0;
          end
        end
        ST_RUN: begin
          mem_r[idx_r] <= next_state_s;
          if (fire_s) begin
            spikes_r[idx_r] <= 1'b1;
          end
          if (idx_r == LAST_IDX) begin
            state_r        <= ST_DONE;
            spikes_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (spikes_ready) begin
            step_count_r   <= step_count_r + 16'd1;
            state_r        <= ST_IDLE;
            spikes_valid_r <= 1'b0;
            step_ready_r   <= 1'b1;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          step_ready_r   <= 1'b1;
          spikes_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign step_ready   = step_ready_r;
  assign spikes_valid = spikes_valid_r;
  assign spikes       = spikes_r;
  assign threshold    = threshold_r;
  assign step_count   = step_count_r;
  assign rd_state     = mem_r[rd_idx];

endmodule
